// File: rtl/seven_seg_capture_if.sv
// Display-bus bundle: observed segment/select pins plus recovered per-digit state.
interface seven_seg_capture_if #(
  parameter int N_DIGITS = 6
);
  logic [6:0]            seg_in;
  logic [N_DIGITS-1:0]   dig_sel;
  logic [4*N_DIGITS-1:0] hex_out;
  logic [N_DIGITS-1:0]   valid;
  logic [N_DIGITS-1:0]   err;
  logic                  upd;
  logic [2:0]            upd_idx;

  modport master (
    output seg_in, dig_sel,
    input  hex_out, valid, err, upd, upd_idx
  );

  modport slave (
    input  seg_in, dig_sel,
    output hex_out, valid, err, upd, upd_idx
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus after a stability window.
// Define SEG_CAPTURE_TIMEOUT_EN to age out digits not refreshed within TIMEOUT_CYCLES.
module seven_seg_capture #(
  parameter int N_DIGITS       = 6,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  seven_seg_capture_if.slave  bus
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  if (N_DIGITS < 1 || N_DIGITS > 8 || STABLE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("seven_seg_capture: illegal parameter value");
  end

  logic [6:0]            r_seg_s1, r_seg_s2, r_seg_prev;
  logic [N_DIGITS-1:0]   r_sel_s1, r_sel_s2, r_sel_prev;
  logic [CNT_W-1:0]      r_cnt;
  logic [4*N_DIGITS-1:0] r_hex;
  logic [N_DIGITS-1:0]   r_valid, r_err;
  logic                  r_upd;
  logic [2:0]            r_upd_idx;

  logic       w_onehot, w_same, w_commit, w_legal, w_blank;
  logic [3:0] w_glyph;
  logic [2:0] w_idx;

  assign w_onehot = (r_sel_s2 != '0) &&
                    ((r_sel_s2 & (r_sel_s2 - N_DIGITS'(1))) == '0);
  assign w_same   = (r_seg_s2 == r_seg_prev) && (r_sel_s2 == r_sel_prev);
  assign w_commit = w_same && w_onehot && (r_cnt == CNT_W'(STABLE_CYCLES - 1));
  assign w_blank  = (r_seg_s2 == 7'h7F);

  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_sel_s2[i]) w_idx = 3'(i);
    end
  end

  always_comb begin
    w_legal = 1'b1;
    w_glyph = 4'h0;
    case (r_seg_s2)
      7'b1000000: w_glyph = 4'h0;
      7'b1111001: w_glyph = 4'h1;
      7'b0100100: w_glyph = 4'h2;
      7'b0110000: w_glyph = 4'h3;
      7'b0011001: w_glyph = 4'h4;
      7'b0010010: w_glyph = 4'h5;
      7'b0000010: w_glyph = 4'h6;
      7'b1111000: w_glyph = 4'h7;
      7'b0000000: w_glyph = 4'h8;
      7'b0010000: w_glyph = 4'h9;
      7'b0001000: w_glyph = 4'hA;
      7'b0000011: w_glyph = 4'hB;
      7'b1000110: w_glyph = 4'hC;
      7'b0100001: w_glyph = 4'hD;
      7'b0000110: w_glyph = 4'hE;
      7'b0001110: w_glyph = 4'hF;
      default:    w_legal = 1'b0;
    endcase
  end

  // Two-flop synchronizers plus one-deep history of the synced sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seg_s1   <= 7'h7F;
      r_seg_s2   <= 7'h7F;
      r_seg_prev <= 7'h7F;
      r_sel_s1   <= '0;
      r_sel_s2   <= '0;
      r_sel_prev <= '0;
      r_cnt      <= '0;
    end else begin
      r_seg_s1   <= bus.seg_in;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
      r_sel_s1   <= bus.dig_sel;
      r_sel_s2   <= r_sel_s1;
      r_sel_prev <= r_sel_s2;
      if (w_same && w_onehot) begin
        if (r_cnt != CNT_W'(STABLE_CYCLES)) r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= w_onehot ? CNT_W'(1) : '0;
      end
    end
  end

`ifdef SEG_CAPTURE_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [AGE_W-1:0] r_age [N_DIGITS];
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hex     <= '0;
      r_valid   <= '0;
      r_err     <= '0;
      r_upd     <= 1'b0;
      r_upd_idx <= 3'd0;
`ifdef SEG_CAPTURE_TIMEOUT_EN
      for (int i = 0; i < N_DIGITS; i++) r_age[i] <= '0;
`endif
    end else begin
      r_upd     <= w_commit;
      r_upd_idx <= w_commit ? w_idx : 3'd0;
      for (int i = 0; i < N_DIGITS; i++) begin
        if (w_commit && r_sel_s2[i]) begin
          r_hex[4*i +: 4] <= w_legal ? w_glyph : 4'h0;
          r_valid[i]      <= w_legal;
          r_err[i]        <= !w_legal && !w_blank;
`ifdef SEG_CAPTURE_TIMEOUT_EN
          r_age[i]        <= '0;
        end else begin
          if (r_age[i] != AGE_W'(TIMEOUT_CYCLES)) begin
            r_age[i] <= r_age[i] + AGE_W'(1);
          end else begin
            r_hex[4*i +: 4] <= 4'h0;
            r_valid[i]      <= 1'b0;
            r_err[i]        <= 1'b0;
          end
`endif
        end
      end
    end
  end

  assign bus.hex_out = r_hex;
  assign bus.valid   = r_valid;
  assign bus.err     = r_err;
  assign bus.upd     = r_upd;
  assign bus.upd_idx = r_upd_idx;
endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: sample-history model checked every cycle plus directed literal checks.
module tb_seven_seg_capture;
  localparam int N  = 6;
  localparam int ST = 4;
  localparam int TO = 50;
`ifdef SEG_CAPTURE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seven_seg_capture_if #(.N_DIGITS(N)) bus ();

  seven_seg_capture #(
    .N_DIGITS(N), .STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  logic [6:0] GLYPH [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int tests = 0, fails = 0, shown = 0;
  int edge_no = 0, upd_cnt = 0, upd_edge = 0;
  logic [2:0] last_idx = 3'd0;

  // Model: raw pin samples, newest first; a sample with no select bit means "nothing valid".
  logic [N+6:0]   hist [ST+3];
  logic [4*N-1:0] m_hex = '0;
  logic [N-1:0]   m_valid = '0, m_err = '0;
  logic           m_upd = 1'b0;
  logic [2:0]     m_idx = 3'd0;
  int             last_commit [N];

  initial foreach (hist[j]) hist[j] = '0;
  initial foreach (last_commit[i]) last_commit[i] = 0;

  function automatic int decode(input logic [6:0] s);
    for (int g = 0; g < 16; g++) if (GLYPH[g] == s) return g;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [N+6:0] s;
    logic commit;
    int v, d;
    if (rst) begin
      foreach (hist[j]) hist[j] = '0;
      m_hex = '0; m_valid = '0; m_err = '0; m_upd = 1'b0; m_idx = 3'd0;
      foreach (last_commit[i]) last_commit[i] = edge_no;
    end else begin
      edge_no++;
      for (int j = ST + 2; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {bus.dig_sel, bus.seg_in};
      m_upd = 1'b0; m_idx = 3'd0;
      if (TO_EN) begin
        for (int i = 0; i < N; i++) begin
          if (edge_no - last_commit[i] > TO) begin
            m_hex[4*i +: 4] = 4'h0; m_valid[i] = 1'b0; m_err[i] = 1'b0;
          end
        end
      end
      // Commit when exactly ST identical one-hot samples end two edges back.
      s = hist[2];
      commit = ($countones(s[N+6:7]) == 1) && (hist[ST+2] != s);
      for (int j = 3; j <= ST + 1; j++) if (hist[j] != s) commit = 1'b0;
      if (commit) begin
        d = 0;
        for (int i = 0; i < N; i++) if (s[7+i]) d = i;
        v = decode(s[6:0]);
        m_hex[4*d +: 4] = (v >= 0) ? 4'(v) : 4'h0;
        m_valid[d]      = (v >= 0);
        m_err[d]        = (v < 0) && (s[6:0] != 7'h7F);
        last_commit[d]  = edge_no;
        m_upd = 1'b1; m_idx = 3'(d);
      end
    end
  end

  always @(negedge clk) begin
    tests++;
    if ({bus.hex_out, bus.valid, bus.err, bus.upd, bus.upd_idx} !==
        {m_hex, m_valid, m_err, m_upd, m_idx}) begin
      fails++;
      if (shown < 20) begin
        shown++;
        $display("FAIL model_cmp edge %0d: got hex=%h v=%b e=%b upd=%b idx=%0d, expected hex=%h v=%b e=%b upd=%b idx=%0d",
                 edge_no, bus.hex_out, bus.valid, bus.err, bus.upd, bus.upd_idx,
                 m_hex, m_valid, m_err, m_upd, m_idx);
      end
    end
    if (bus.upd === 1'b1) begin
      upd_cnt++;
      upd_edge = edge_no;
      last_idx = bus.upd_idx;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic hold(input logic [6:0] seg, input logic [N-1:0] sel, input int n);
    bus.seg_in  = seg;
    bus.dig_sel = sel;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int e0, c0;
    bus.seg_in  = 7'h7F;
    bus.dig_sel = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hex",   32'(bus.hex_out), 32'h0);
    chk("reset_valid", 32'(bus.valid),   32'h0);
    chk("reset_err_upd", {bus.err, bus.upd, bus.upd_idx}, 32'h0);
    rst = 1'b0;

    // Digit 0 shows "2": commit on the sixth edge counting the first sample.
    e0 = edge_no; c0 = upd_cnt;
    hold(7'b0100100, 6'b000001, 10);
    chk("t1_latency", 32'(upd_edge - e0), 32'd6);
    chk("t1_upd_cnt", 32'(upd_cnt - c0),  32'd1);
    chk("t1_idx",     32'(last_idx),      32'd0);
    chk("t1_hex",     32'(bus.hex_out[3:0]), 32'h2);
    chk("t1_valid",   32'(bus.valid),     32'b000001);
    chk("t1_err",     32'(bus.err),       32'h0);

    // Sweep all glyphs on digit 3, then re-display F after an interruption.
    c0 = upd_cnt;
    for (int g = 0; g < 16; g++) begin
      hold(GLYPH[g], 6'b001000, 8);
      chk($sformatf("sweep_hex_%0d", g), 32'(bus.hex_out[15:12]), 32'(g));
    end
    chk("sweep_upd_cnt", 32'(upd_cnt - c0), 32'd16);
    chk("sweep_idx",     32'(last_idx),     32'd3);
    chk("sweep_valid3",  32'(bus.valid[3]), 32'd1);
    hold(GLYPH[15], 6'b000000, 3);
    c0 = upd_cnt;
    hold(GLYPH[15], 6'b001000, 8);
    chk("redisplay_upd", 32'(upd_cnt - c0), 32'd1);

    // Digit 5: A, blank, then an illegal pattern.
    hold(7'b0001000, 6'b100000, 8);
    chk("d5_A", {bus.hex_out[23:20], 2'b00, bus.valid[5], bus.err[5]}, {4'hA, 2'b00, 1'b1, 1'b0});
    hold(7'b1111111, 6'b100000, 8);
    chk("d5_blank", {bus.hex_out[23:20], 2'b00, bus.valid[5], bus.err[5]}, {4'h0, 2'b00, 1'b0, 1'b0});
    hold(7'b0101010, 6'b100000, 8);
    chk("d5_bad", {bus.hex_out[23:20], 2'b00, bus.valid[5], bus.err[5]}, {4'h0, 2'b00, 1'b0, 1'b1});

    // Illegal selects and a pattern toggling faster than the window never commit.
    c0 = upd_cnt;
    hold(GLYPH[1], 6'b000011, 20);
    hold(GLYPH[4], 6'b000000, 20);
    for (int k = 0; k < 8; k++) hold((k % 2) ? GLYPH[8] : GLYPH[9], 6'b000001, 3);
    hold(7'h7F, 6'b000000, 6);
    chk("no_commit_upd", 32'(upd_cnt - c0), 32'd0);

    // Digit 1 shows 7, then is deselected; with aging it clears 51 edges after commit.
    hold(GLYPH[7], 6'b000010, 10);
    chk("age_commit", 32'(bus.hex_out[7:4]), 32'h7);
    c0 = upd_cnt;
    hold(7'h7F, 6'b000000, upd_edge + TO - edge_no);
    chk("age_at_50", 32'(bus.valid[1]), 32'd1);
    hold(7'h7F, 6'b000000, 1);
    chk("age_at_51", 32'(bus.valid[1]), TO_EN ? 32'd0 : 32'd1);
    chk("age_no_upd", 32'(upd_cnt - c0), 32'd0);

    // Reset one edge before a commit, then the full window after release.
    c0 = upd_cnt;
    hold(GLYPH[7], 6'b000100, 5);
    rst = 1'b1;
    #1;
    chk("midrst_zero", {8'h0, bus.hex_out}, 32'h0);
    chk("midrst_flags", {bus.valid, bus.err, bus.upd}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    e0 = edge_no;
    chk("midrst_no_upd", 32'(upd_cnt - c0), 32'd0);
    hold(GLYPH[7], 6'b000100, 8);
    chk("midrst_latency", 32'(upd_edge - e0), 32'd6);
    chk("midrst_hex",     32'(bus.hex_out),   32'h000700);
    chk("midrst_valid",   32'(bus.valid),     32'b000100);

    hold(7'h7F, 6'b000000, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
